// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
// Build option: SEQ_MULT_EARLY_EXIT_EN (see seq_mult.sv).
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult_twos_neg.sv
// Conditional two's-complement negate: q = neg ? -d : d.
// Used for operand magnitudes and the product sign fix.
module twos_neg #(
  parameter int WIDTH = 8
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  assign q = neg ? (~d + WIDTH'(1)) : d;

endmodule

// File: rtl/seq_mult.sv
// Radix-2 shift-and-add multiplier, signed/unsigned per operation.
// Define SEQ_MULT_EARLY_EXIT_EN to finish once the multiplier runs out of ones.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               signed_mode,
  output logic [2*WIDTH-1:0] out,
  output logic               finish,
  output logic               busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_nxt;
  logic [PW-1:0]    prod;
  logic [CW-1:0]    cnt;
  logic             neg_flag;
  logic             sgn;
  logic             last;

  twos_neg #(.WIDTH(WIDTH)) u_neg_a (
    .neg (signed_mode & a_in[WIDTH-1]),
    .d   (a_in),
    .q   (a_mag)
  );

  twos_neg #(.WIDTH(WIDTH)) u_neg_b (
    .neg (signed_mode & b_in[WIDTH-1]),
    .d   (b_in),
    .q   (b_mag)
  );

  // Sign fix applies to the accumulator value including this edge's add.
  twos_neg #(.WIDTH(PW)) u_neg_p (
    .neg (sgn & neg_flag),
    .d   (acc_nxt),
    .q   (prod)
  );

  assign addend  = PW'(mcand) << cnt;
  assign acc_nxt = mplier[0] ? (acc + addend) : acc;

`ifdef SEQ_MULT_EARLY_EXIT_EN
  assign last = (mplier >> 1) == '0;
`else
  assign last = cnt == CW'(WIDTH - 1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_flag <= 1'b0;
      sgn      <= 1'b0;
      out      <= '0;
      finish   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand    <= a_mag;
            mplier   <= b_mag;
            sgn      <= signed_mode;
            neg_flag <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            out    <= prod;
            finish <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          finish <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
